// File: rtl/ram_pkg.sv
// Shared definitions for the burst RAM controller: defaults and FSM encoding.
package ram_pkg;

    localparam int RAM_DATA_WIDTH = 64;
    localparam int RAM_ADDR_WIDTH = 11;
    localparam int RAM_LEN_WIDTH  = 3;
    localparam int RAM_NUM_BYTES  = RAM_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2
    } state_t;

endpackage

// File: rtl/ram_array.sv
// Byte-lane storage: per-byte write enable, 1-cycle synchronous read gated by re.
// The read register only updates on re, so it holds its value under backpressure.
// Byte lane 0 is the most significant byte of the word (big-endian lane numbering
// carried over from the original bus).
module ram_array
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = RAM_DATA_WIDTH,
    parameter int ADDR_WIDTH = RAM_ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic                    re,
    output logic [DATA_WIDTH-1:0]   q
);

    localparam int NUM_LANES = DATA_WIDTH / 8;
    localparam int DEPTH     = 2 ** ADDR_WIDTH;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        localparam int HI = DATA_WIDTH - 1 - 8 * g;

        logic [7:0] mem [DEPTH];
        logic [7:0] q_r;

        // Lane write when enabled, lane read into its output register on re
        always_ff @(posedge clk) begin
            if (we && be[g])
                mem[addr] <= wdata[HI -: 8];
            if (re)
                q_r <= mem[addr];
        end

        assign q[HI -: 8] = q_r;
    end

endmodule

// File: rtl/ram_burst_ctrl.sv
// Burst RAM controller: request / write-data / read-data channels over ram_array.
// Holds the FSM, the wrapping address counter, the beat counter and the read
// output valid/last flags; read data comes straight from the array's read register.
module ram_burst_ctrl
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = RAM_DATA_WIDTH,
    parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
    parameter int LEN_WIDTH  = RAM_LEN_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_isReading,
    input  logic [ADDR_WIDTH-1:0]   req_address,
    input  logic [LEN_WIDTH-1:0]    req_len,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_byteen,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_last,
    output logic                    busy,
    output logic                    done
);

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [LEN_WIDTH-1:0]    cnt;
    logic [DATA_WIDTH-1:0]   q;
    logic                    wr_acc;
    logic                    rd_issue;

    // wr_ready is only high in WRITE; a read issues when the output register is free or draining
    assign wr_acc   = wr_valid && wr_ready;
    assign rd_issue = (state == S_READ) && (!rd_valid || rd_ready);

    ram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .be    (wr_byteen),
        .addr  (addr),
        .wdata (wr_data),
        .re    (rd_issue),
        .q     (q)
    );

    // Array output has no reset; mask it so rd_data reads zero whenever no beat is presented
    assign rd_data = rd_valid ? q : '0;

    // Burst FSM with registered handshake/status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
            wr_ready  <= 1'b0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            addr      <= '0;
            cnt       <= '0;
        end else begin
            done <= rd_valid && rd_ready && rd_last;

            // Output register drains on its own, independent of FSM state
            if (rd_valid && rd_ready) begin
                rd_valid <= 1'b0;
                rd_last  <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        addr      <= req_address;
                        cnt       <= req_len;
                        busy      <= 1'b1;
                        req_ready <= 1'b0;
                        if (req_isReading) begin
                            state <= S_READ;
                        end else begin
                            state    <= S_WRITE;
                            wr_ready <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    if (wr_acc) begin
                        addr <= addr + 1'b1;
                        cnt  <= cnt - 1'b1;
                        if (cnt == '0) begin
                            state     <= S_IDLE;
                            wr_ready  <= 1'b0;
                            busy      <= 1'b0;
                            req_ready <= 1'b1;
                            done      <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    if (rd_issue) begin
                        rd_valid <= 1'b1;
                        rd_last  <= (cnt == '0);
                        addr     <= addr + 1'b1;
                        cnt      <= cnt - 1'b1;
                        if (cnt == '0) begin
                            state     <= S_IDLE;
                            busy      <= 1'b0;
                            req_ready <= 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    wr_ready  <= 1'b0;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Directed bench for ram_burst_ctrl with a read-beat scoreboard queue.
module tb_ram_burst_ctrl;

    localparam int DW = 64;
    localparam int AW = 11;
    localparam int LW = 3;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_isReading = 1'b0;
    logic [AW-1:0] req_address = '0;
    logic [LW-1:0] req_len = '0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [DW-1:0] wr_data = '0;
    logic [DW/8-1:0] wr_byteen = '0;
    logic          rd_valid;
    logic          rd_ready = 1'b1;
    logic [DW-1:0] rd_data;
    logic          rd_last;
    logic          busy;
    logic          done;

    ram_burst_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_isReading (req_isReading),
        .req_address   (req_address),
        .req_len       (req_len),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_data       (wr_data),
        .wr_byteen     (wr_byteen),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_data       (rd_data),
        .rd_last       (rd_last),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    int    cyc = 0;
    int    n_chk = 0;
    int    n_fail = 0;
    int    done_cnt = 0;
    beat_t expq[$];
    int    beat_cyc[$];
    logic [DW-1:0] wbuf [8];

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d, input logic l);
        beat_t b;
        b.d = d;
        b.l = l;
        expq.push_back(b);
    endtask

    task automatic chk_reset(input string pfx);
        chk({pfx, "_req_ready"}, req_ready, 1);
        chk({pfx, "_wr_ready"},  wr_ready,  0);
        chk({pfx, "_rd_valid"},  rd_valid,  0);
        chk({pfx, "_rd_data"},   rd_data,   0);
        chk({pfx, "_rd_last"},   rd_last,   0);
        chk({pfx, "_busy"},      busy,      0);
        chk({pfx, "_done"},      done,      0);
    endtask

    // Scoreboard: every read handshake pops the next expected beat; also counts done pulses
    always @(negedge clk) begin
        beat_t b;
        if (done) done_cnt++;
        if (!reset && rd_valid && rd_ready) begin
            if (expq.size() == 0) begin
                chk("rd_unexpected_beat", 1, 0);
            end else begin
                b = expq.pop_front();
                chk("rd_data", rd_data, b.d);
                chk("rd_last", rd_last, b.l);
                beat_cyc.push_back(cyc);
            end
        end
    end

    task automatic send_req(input logic rd, input logic [AW-1:0] a, input logic [LW-1:0] l);
        int t = 0;
        req_valid     = 1'b1;
        req_isReading = rd;
        req_address   = a;
        req_len       = l;
        while (!req_ready && t < 100) begin step(); t++; end
        chk("req_accept_timeout", t < 100, 1);
        step();
        req_valid = 1'b0;
    endtask

    // Write nbeats of the burst from wbuf; stall_at >= 0 drops wr_valid for 5 cycles before that beat
    task automatic do_write(input logic [AW-1:0] a, input logic [LW-1:0] l,
                            input logic [DW/8-1:0] be, input int nbeats, input int stall_at);
        int d0 = done_cnt;
        int t;
        send_req(1'b0, a, l);
        for (int i = 0; i < nbeats; i++) begin
            if (i == stall_at) begin
                wr_valid = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    step();
                    chk("stall_busy", busy, 1);
                    chk("stall_addr", dut.addr, AW'(a + AW'(i)));
                end
            end
            wr_valid  = 1'b1;
            wr_data   = wbuf[i];
            wr_byteen = be;
            t = 0;
            while (!wr_ready && t < 100) begin step(); t++; end
            chk("wr_ready_timeout", t < 100, 1);
            step();
        end
        wr_valid = 1'b0;
        if (nbeats == int'(l) + 1) begin
            step();
            step();
            chk("wr_done_count", done_cnt - d0, 1);
        end
    endtask

    // Issue a read burst and wait for the scoreboard to drain
    task automatic do_read(input logic [AW-1:0] a, input logic [LW-1:0] l);
        int d0 = done_cnt;
        int t = 0;
        send_req(1'b1, a, l);
        while (expq.size() != 0 && t < 200) begin step(); t++; end
        chk("rd_drain_timeout", t < 200, 1);
        step();
        step();
        chk("rd_done_count", done_cnt - d0, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        // Reset state
        step();
        chk_reset("rst");
        step();
        reset = 1'b0;
        step();

        // Write burst then read back
        wbuf[0] = 64'hff03; wbuf[1] = 64'hff04; wbuf[2] = 64'hff05; wbuf[3] = 64'hff06;
        do_write(11'd1024, 3'd3, 8'hFF, 4, -1);
        push(64'hff03, 0); push(64'hff04, 0); push(64'hff05, 0); push(64'hff06, 1);
        beat_cyc.delete();
        do_read(11'd1024, 3'd3);
        chk("burst_beat_count", beat_cyc.size(), 4);
        for (int k = 1; k < beat_cyc.size(); k++)
            chk("burst_consecutive", beat_cyc[k] - beat_cyc[0], k);

        // Backpressure: hold the first beat for 3 cycles
        rd_ready = 1'b0;
        push(64'hff03, 0); push(64'hff04, 1);
        send_req(1'b1, 11'd1024, 3'd1);
        t = 0;
        while (!rd_valid && t < 50) begin step(); t++; end
        chk("bp_valid_timeout", t < 50, 1);
        for (int s = 0; s < 3; s++) begin
            chk("bp_rd_data", rd_data, 64'hff03);
            chk("bp_rd_last", rd_last, 0);
            chk("bp_second_not_issued", busy, 1);
            step();
        end
        rd_ready = 1'b1;
        t = 0;
        while (expq.size() != 0 && t < 50) begin step(); t++; end
        chk("bp_drain_timeout", t < 50, 1);
        step();
        chk("bp_idle", busy, 0);

        // Address wrap
        wbuf[0] = 64'd1; wbuf[1] = 64'd2; wbuf[2] = 64'd3; wbuf[3] = 64'd4;
        do_write(11'd2046, 3'd3, 8'hFF, 4, -1);
        push(64'd1, 1); do_read(11'd2046, 3'd0);
        push(64'd2, 1); do_read(11'd2047, 3'd0);
        push(64'd3, 1); do_read(11'd0, 3'd0);
        push(64'd4, 1); do_read(11'd1, 3'd0);

        // Byte enables: bytes 0..3 are the upper half of the word
        wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        do_write(11'd5, 3'd0, 8'hFF, 1, -1);
        wbuf[0] = 64'h0;
        do_write(11'd5, 3'd0, 8'h0F, 1, -1);
        push(64'h0000_0000_FFFF_FFFF, 1);
        do_read(11'd5, 3'd0);

        // Stall mid-burst
        wbuf[0] = 64'h11; wbuf[1] = 64'h22; wbuf[2] = 64'h33;
        do_write(11'd100, 3'd2, 8'hFF, 3, 1);
        push(64'h11, 0); push(64'h22, 0); push(64'h33, 1);
        do_read(11'd100, 3'd2);

        // Reset after 2 of 4 beats
        wbuf[0] = 64'hAA01; wbuf[1] = 64'hAA02; wbuf[2] = 64'hAA03; wbuf[3] = 64'hAA04;
        do_write(11'd1024, 3'd3, 8'hFF, 2, -1);
        wr_valid  = 1'b1;
        wr_data   = 64'hDEAD;
        reset     = 1'b1;
        #1;
        chk_reset("midrst");
        step();
        wr_valid = 1'b0;
        step();
        reset = 1'b0;
        step();
        push(64'hAA01, 0); push(64'hAA02, 0); push(64'hff05, 0); push(64'hff06, 1);
        do_read(11'd1024, 3'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
